onehot_encoder: RTL and testbench



---
 rtl/onehot_pkg.sv | 29 ++
 rtl/onehot_encoder_prio_enc8.sv | 17 +
 rtl/onehot_encoder.sv | 93 +++++++++
 tb/tb_onehot_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared constants, FSM state type and the lowest-set-bit
// code function for the one-hot encoder.
//   VEC_W      - event vector width (8)
//   CODE_W     - output code width (4)
//   CODE_NONE  - code emitted for an all-zero vector
//   state_e    - IDLE (nothing pending) / EMIT (codes being emitted)
//   priority_code(v) - 0 if v==0, else index of lowest set bit + 1
package onehot_pkg;

   localparam int VEC_W  = 8;
   localparam int CODE_W = 4;
   localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic logic [CODE_W-1:0] priority_code(input logic [VEC_W-1:0] v);
      logic [CODE_W-1:0] c;
      c = CODE_NONE;
      // Scan high to low so the lowest set bit wins.
      for (int i = VEC_W - 1; i >= 0; i--) begin
         if (v[i]) c = CODE_W'(i + 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/onehot_encoder_prio_enc8.sv
// prio_enc8: combinational lowest-set-bit encoder.
//   vec_i  - input vector
//   code_o - priority_code(vec_i)
//   rest_o - vec_i with its lowest set bit cleared
module prio_enc8
   import onehot_pkg::*;
(
   input  logic [VEC_W-1:0]  vec_i,
   output logic [CODE_W-1:0] code_o,
   output logic [VEC_W-1:0]  rest_o
);

   assign code_o = priority_code(vec_i);
   // x & (x-1) drops the lowest set bit; zero stays zero.
   assign rest_o = vec_i & (vec_i - VEC_W'(1));

endmodule

// File: rtl/onehot_encoder.sv
// onehot_encoder: takes an 8-bit event vector and emits the code of each set
// bit, lowest first, one per cycle (bit i -> code i+1, zero vector -> code 0).
//   clk, rst              - clock, async active-high reset
//   in_vec/in_valid       - event vector and its valid (input handshake)
//   in_ready              - block can accept in_vec this cycle
//   out_code/out_valid    - registered code and its valid
//   out_last              - current code is the last for its vector
//   out_ready             - consumer takes out_code this cycle
module onehot_encoder
   import onehot_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [VEC_W-1:0]  in_vec,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   state_e            state_q, state_d;
   logic [VEC_W-1:0]  pend_q, pend_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;

   logic              accept, pop;
   logic [VEC_W-1:0]  enc_in, enc_rest;
   logic [CODE_W-1:0] enc_code;

   assign pop      = valid_q && out_ready;
   // A new vector can enter on the same cycle the previous final code leaves.
   assign in_ready = (state_q == IDLE) || (pop && last_q);
   assign accept   = in_valid && in_ready;

   // One encoder shared by both paths: accept and pop-with-pending are
   // exclusive because accept outside IDLE requires pend to be empty.
   assign enc_in = accept ? in_vec : pend_q;

   prio_enc8 u_enc (
      .vec_i  (enc_in),
      .code_o (enc_code),
      .rest_o (enc_rest)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      code_d  = code_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (accept) begin
         pend_d  = enc_rest;
         code_d  = enc_code;
         last_d  = (enc_rest == '0);
         valid_d = 1'b1;
         state_d = EMIT;
      end else if (pop) begin
         if (pend_q != '0) begin
            pend_d = enc_rest;
            code_d = enc_code;
            last_d = (enc_rest == '0);
         end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         code_q  <= CODE_NONE;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_code  = code_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_onehot_encoder.sv
module tb_onehot_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_vec;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_code;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;

   always #5 clk = ~clk;

   onehot_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_vec    (in_vec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [3:0] code;
      logic       last;
   } beat_t;

   typedef struct {
      logic [7:0] vec;
      int         nbeats;
   } vec_t;

   beat_t exp_q[$];
   int    beat_cyc[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    nbeats = 0;

   logic       have_stall = 1'b0;
   logic [3:0] stall_code;
   logic       stall_last;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: bit i -> code i+1, lowest first; zero vector -> single code 0.
   task automatic push_model(input logic [7:0] v);
      beat_t b;
      logic [7:0] rest;
      if (v == 8'h00) begin
         b.code = 4'd0; b.last = 1'b1; exp_q.push_back(b);
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
               rest   = v >> (i + 1);
               b.code = 4'(i + 1);
               b.last = (rest == 8'h00);
               exp_q.push_back(b);
            end
         end
      end
   endtask

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      beat_t e;
      cyc++;
      if (rst) begin
         exp_q.delete();
         have_stall = 1'b0;
      end else begin
         if (have_stall) begin
            check(out_valid && out_code == stall_code && out_last == stall_last,
                  "stall_hold_code", int'(out_code), int'(stall_code));
            have_stall = 1'b0;
         end
         if (out_valid && out_ready) begin
            nbeats++;
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_beat", int'(out_code), -1);
            end else begin
               e = exp_q.pop_front();
               check(out_code == e.code, "beat_code", int'(out_code), int'(e.code));
               check(out_last == e.last, "beat_last", int'(out_last), int'(e.last));
            end
            check(in_ready == out_last, "in_ready_on_pop", int'(in_ready), int'(out_last));
         end else if (out_valid) begin
            have_stall = 1'b1;
            stall_code = out_code;
            stall_last = out_last;
            check(in_ready == 1'b0, "in_ready_on_stall", int'(in_ready), 0);
         end
         if (in_valid && in_ready) push_model(in_vec);
      end
   end

   // Present v until accepted; leaves in_valid low #1 after the accept edge.
   task automatic send_vec(input logic [7:0] v);
      bit ok = 1'b0;
      in_vec   = v;
      in_valid = 1'b1;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      check(ok, "accept_timeout", int'(ok), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check(out_valid == 1'b1, "first_code_latency", int'(out_valid), 1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      check(done, "drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      vec_t tbl[6];
      int   b0;
      bit   seen;

      tbl[0] = '{vec: 8'b0000_0001, nbeats: 1};
      tbl[1] = '{vec: 8'b1010_0100, nbeats: 3};
      tbl[2] = '{vec: 8'h00,        nbeats: 1};
      tbl[3] = '{vec: 8'b1000_0000, nbeats: 1};
      tbl[4] = '{vec: 8'b0101_1010, nbeats: 4};
      tbl[5] = '{vec: 8'h81,        nbeats: 2};

      rst = 1'b1; in_vec = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
      check(out_code == 4'd0,  "reset_out_code",  int'(out_code), 0);
      check(out_last == 1'b0,  "reset_out_last",  int'(out_last), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);

      // Table-driven vectors, consumer always ready.
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         nbeats = 0;
         send_vec(tbl[i].vec);
         drain();
         check(nbeats == tbl[i].nbeats, "beat_count", nbeats, tbl[i].nbeats);
      end

      // 0xFF with out_ready pattern 1,0,0 repeating: every code held while stalled.
      nbeats = 0;
      out_ready = 1'b1;
      send_vec(8'hFF);
      seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         out_ready = (k % 3 == 0);
         @(posedge clk); #2;
         if (exp_q.size() == 0 && !out_valid) seen = 1'b1;
      end
      out_ready = 1'b1;
      check(seen, "stall_drain", int'(seen), 1);
      check(nbeats == 8, "stall_beat_count", nbeats, 8);

      // Back-to-back vectors: 8, 1, 2 on consecutive cycles.
      drain();
      beat_cyc.delete();
      send_vec(8'b1000_0000);
      send_vec(8'b0000_0011);
      drain();
      check(beat_cyc.size() == 3, "b2b_beats", beat_cyc.size(), 3);
      if (beat_cyc.size() == 3) begin
         b0 = beat_cyc[0];
         check(beat_cyc[2] - b0 == 2, "b2b_no_bubble", beat_cyc[2] - b0, 2);
      end

      // Reset mid-emit of 0xF0 once code 5 has been taken.
      send_vec(8'hF0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (out_valid && out_code == 4'd5) seen = 1'b1;
      end
      check(seen, "saw_code5", int'(seen), 1);
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check(out_valid == 1'b0, "midreset_out_valid", int'(out_valid), 0);
      check(out_code == 4'd0,  "midreset_out_code",  int'(out_code), 0);
      check(out_last == 1'b0,  "midreset_out_last",  int'(out_last), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      nbeats = 0;
      send_vec(8'h02);
      drain();
      check(nbeats == 1, "post_reset_beats", nbeats, 1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
